// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory on the DMA master port: INCR/FIXED bursts, independent
// write and read paths, one outstanding transaction per direction.
module axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    CLK_1,
    input  logic                    RESET_1,
    input  logic [ADDR_WIDTH-1:0]   dma_m_awaddr,
    input  logic [ID_WIDTH-1:0]     dma_m_awid,
    input  logic [7:0]              dma_m_awlen,
    input  logic [2:0]              dma_m_awsize,
    input  logic [1:0]              dma_m_awburst,
    input  logic                    dma_m_awvalid,
    output logic                    dma_m_awready,
    input  logic [DATA_WIDTH-1:0]   dma_m_wdata,
    input  logic [DATA_WIDTH/8-1:0] dma_m_wstrb,
    input  logic                    dma_m_wlast,
    input  logic                    dma_m_wvalid,
    output logic                    dma_m_wready,
    output logic [ID_WIDTH-1:0]     dma_m_bid,
    output logic [1:0]              dma_m_bresp,
    output logic                    dma_m_bvalid,
    input  logic                    dma_m_bready,
    input  logic [ADDR_WIDTH-1:0]   dma_m_araddr,
    input  logic [ID_WIDTH-1:0]     dma_m_arid,
    input  logic [7:0]              dma_m_arlen,
    input  logic [2:0]              dma_m_arsize,
    input  logic [1:0]              dma_m_arburst,
    input  logic                    dma_m_arvalid,
    output logic                    dma_m_arready,
    output logic [DATA_WIDTH-1:0]   dma_m_rdata,
    output logic [ID_WIDTH-1:0]     dma_m_rid,
    output logic [1:0]              dma_m_rresp,
    output logic                    dma_m_rlast,
    output logic                    dma_m_rvalid,
    input  logic                    dma_m_rready
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Range check uses the full index so high address bits are never aliased into range.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH:0] start_idx;
        logic [ADDR_WIDTH:0] end_idx;
        start_idx = {1'b0, addr >> SHIFT};
        end_idx   = start_idx + {{(ADDR_WIDTH - 7){1'b0}}, len};
        burst_err = burst[1] || (size != 3'(SHIFT))
                    || ((burst == BURST_INCR) && (end_idx > LAST_IDX))
                    || ((burst == BURST_FIXED) && (start_idx > LAST_IDX));
    endfunction

    w_state_t            w_state_reg, w_state_next;
    r_state_t            r_state_reg, r_state_next;
    logic                ready_en_reg;

    logic [IDXW-1:0]     w_idx_reg;
    logic [ID_WIDTH-1:0] w_id_reg;
    logic [7:0]          w_len_reg;
    logic [1:0]          w_burst_reg;
    logic                w_err_reg, w_last_err_reg;
    logic [8:0]          w_cnt_reg;

    logic [IDXW-1:0]     r_idx_reg;
    logic [ID_WIDTH-1:0] r_id_reg;
    logic [7:0]          r_len_reg;
    logic [1:0]          r_burst_reg;
    logic                r_err_reg, rd_zero_reg;
    logic [8:0]          r_cnt_reg;

    logic aw_hs, w_hs, ar_hs, r_hs, w_is_last, r_is_last, mem_we, mem_re;
    logic [IDXW-1:0]       r_next_idx, rd_idx;
    logic [DATA_WIDTH-1:0] mem_q;

    assign aw_hs      = dma_m_awvalid && dma_m_awready;
    assign w_hs       = dma_m_wvalid && dma_m_wready;
    assign ar_hs      = dma_m_arvalid && dma_m_arready;
    assign r_hs       = dma_m_rvalid && dma_m_rready;
    assign w_is_last  = (w_cnt_reg == {1'b0, w_len_reg});
    assign r_is_last  = (r_cnt_reg == {1'b0, r_len_reg});
    assign mem_we     = w_hs && !w_err_reg && RESET_1;
    assign r_next_idx = (r_burst_reg == BURST_INCR) ? r_idx_reg + IDXW'(1) : r_idx_reg;
    assign rd_idx     = ar_hs ? dma_m_araddr[SHIFT +: IDXW] : r_next_idx;
    assign mem_re     = ar_hs || (r_hs && !r_is_last);

    always_ff @(posedge CLK_1) begin
        if (!RESET_1) begin
            w_state_reg  <= W_IDLE;
            r_state_reg  <= R_IDLE;
            ready_en_reg <= 1'b0;
        end else begin
            w_state_reg  <= w_state_next;
            r_state_reg  <= r_state_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        w_state_next  = w_state_reg;
        dma_m_awready = 1'b0;
        dma_m_wready  = 1'b0;
        dma_m_bvalid  = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                dma_m_awready = ready_en_reg;
                if (dma_m_awvalid && ready_en_reg) w_state_next = W_DATA;
            end
            W_DATA: begin
                dma_m_wready = 1'b1;
                if (dma_m_wvalid && w_is_last) w_state_next = W_RESP;
            end
            W_RESP: begin
                dma_m_bvalid = 1'b1;
                if (dma_m_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next  = r_state_reg;
        dma_m_arready = 1'b0;
        dma_m_rvalid  = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                dma_m_arready = ready_en_reg;
                if (dma_m_arvalid && ready_en_reg) r_state_next = R_DATA;
            end
            R_DATA: begin
                dma_m_rvalid = 1'b1;
                if (dma_m_rready && r_is_last) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK_1) begin
        if (!RESET_1) begin
            w_idx_reg      <= '0;
            w_id_reg       <= '0;
            w_len_reg      <= '0;
            w_burst_reg    <= '0;
            w_err_reg      <= 1'b0;
            w_last_err_reg <= 1'b0;
            w_cnt_reg      <= '0;
        end else if (aw_hs) begin
            w_idx_reg      <= dma_m_awaddr[SHIFT +: IDXW];
            w_id_reg       <= dma_m_awid;
            w_len_reg      <= dma_m_awlen;
            w_burst_reg    <= dma_m_awburst;
            w_err_reg      <= burst_err(dma_m_awaddr, dma_m_awlen, dma_m_awsize, dma_m_awburst);
            w_last_err_reg <= 1'b0;
            w_cnt_reg      <= '0;
        end else if (w_hs) begin
            w_cnt_reg <= w_cnt_reg + 9'd1;
            if (w_burst_reg == BURST_INCR) w_idx_reg <= w_idx_reg + IDXW'(1);
            // wlast must coincide with the final beat; anything else taints the response
            if (dma_m_wlast != w_is_last) w_last_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge CLK_1) begin
        if (!RESET_1) begin
            r_idx_reg   <= '0;
            r_id_reg    <= '0;
            r_len_reg   <= '0;
            r_burst_reg <= '0;
            r_err_reg   <= 1'b0;
            rd_zero_reg <= 1'b1;
            r_cnt_reg   <= '0;
        end else if (ar_hs) begin
            r_idx_reg   <= dma_m_araddr[SHIFT +: IDXW];
            r_id_reg    <= dma_m_arid;
            r_len_reg   <= dma_m_arlen;
            r_burst_reg <= dma_m_arburst;
            r_err_reg   <= burst_err(dma_m_araddr, dma_m_arlen, dma_m_arsize, dma_m_arburst);
            rd_zero_reg <= burst_err(dma_m_araddr, dma_m_arlen, dma_m_arsize, dma_m_arburst);
            r_cnt_reg   <= '0;
        end else if (r_hs && !r_is_last) begin
            r_idx_reg <= r_next_idx;
            r_cnt_reg <= r_cnt_reg + 9'd1;
        end
    end

    // One RAM per byte lane so strobes map onto plain lane write enables.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];
            logic [7:0] lane_q;
            always_ff @(posedge CLK_1) begin
                if (mem_we && dma_m_wstrb[gi]) lane_mem[w_idx_reg] <= dma_m_wdata[8*gi +: 8];
                if (mem_re) lane_q <= lane_mem[rd_idx];
            end
            assign mem_q[8*gi +: 8] = lane_q;
        end
    endgenerate

    assign dma_m_rdata = rd_zero_reg ? '0 : mem_q;
    assign dma_m_rid   = r_id_reg;
    assign dma_m_rresp = ((r_state_reg == R_DATA) && r_err_reg) ? RESP_SLVERR : RESP_OKAY;
    assign dma_m_rlast = (r_state_reg == R_DATA) && r_is_last;
    assign dma_m_bid   = w_id_reg;
    assign dma_m_bresp = ((w_state_reg == W_RESP) && (w_err_reg || w_last_err_reg)) ? RESP_SLVERR : RESP_OKAY;

endmodule
